shift_sequencer: RTL and testbench

Multi-cycle shift unit controller for the lab ALU. It accepts one shift request through a start/ready handshake and walks a 16-bit operand one bit position per clock. It supports logical left, logical right, arithmetic right and rotate left. The result and shifted-out carry are presented with a one-cycle done pulse. It replaces the unrolled combinational loop shifter in the ALU's shift path, so shift area no longer scales with the shift amount.

---
 rtl/shift_sequencer_if.sv | 25 ++
 rtl/shift_sequencer.sv | 131 +++++++++++++
 tb/tb_shift_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// Request/result bundle for the multi-cycle shift sequencer.
// master drives the request, slave (the sequencer) returns status and result.
interface shift_sequencer_if #(
   parameter int WIDTH = 16
) ();
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             cout;

   modport master (
      output start, op, a, b,
      input  ready, busy, done, s, cout
   );

   modport slave (
      input  start, op, a, b,
      output ready, busy, done, s, cout
   );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROL one bit position per clock.
// Optional SHIFT_MULTISTEP_EN: four positions per clock while at least four remain.
module shift_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   shift_sequencer_if.slave   bus
);
   localparam int               CW      = $clog2(WIDTH) + 1;
   localparam logic [WIDTH-1:0] W_VAL   = WIDTH[WIDTH-1:0];
   localparam logic [CW-1:0]    CNT_MAX = WIDTH[CW-1:0];

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_ROL = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             cout_q, cout_d;
   logic [1:0]       op_q, op_d;

   // Returns {cout, s} after a single position.
   function automatic logic [WIDTH:0] step1(input logic [1:0] op, input logic [WIDTH-1:0] v);
      case (op)
         OP_SLL:  step1 = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
         OP_SRL:  step1 = {v[0], 1'b0, v[WIDTH-1:1]};
         OP_SRA:  step1 = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
         OP_ROL:  step1 = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
         default: step1 = {1'b0, v};
      endcase
   endfunction

`ifdef SHIFT_MULTISTEP_EN
   // Four positions at once; cout is the last of the four bits leaving.
   function automatic logic [WIDTH:0] step4(input logic [1:0] op, input logic [WIDTH-1:0] v);
      case (op)
         OP_SLL:  step4 = {v[WIDTH-4], v[WIDTH-5:0], 4'b0000};
         OP_SRL:  step4 = {v[3], 4'b0000, v[WIDTH-1:4]};
         OP_SRA:  step4 = {v[3], {4{v[WIDTH-1]}}, v[WIDTH-1:4]};
         OP_ROL:  step4 = {v[WIDTH-4], v[WIDTH-5:0], v[WIDTH-1:WIDTH-4]};
         default: step4 = {1'b0, v};
      endcase
   endfunction
`endif

   // Next-state, count and datapath update.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      s_d     = s_q;
      cout_d  = cout_q;
      op_d    = op_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               s_d    = bus.a;
               op_d   = bus.op;
               cout_d = 1'b0;
               // Rotate wraps modulo WIDTH; the other ops saturate on the full 16-bit amount.
               if (bus.op == OP_ROL) begin
                  cnt_d = {1'b0, bus.b[CW-2:0]};
               end else if (bus.b >= W_VAL) begin
                  cnt_d = CNT_MAX;
               end else begin
                  cnt_d = bus.b[CW-1:0];
               end
               if (cnt_d == '0) begin
                  state_d = DONE;
               end else begin
                  state_d = SHIFT;
               end
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
`ifdef SHIFT_MULTISTEP_EN
            if (cnt_q >= CW'(4)) begin
               {cout_d, s_d} = step4(op_q, s_q);
               cnt_d         = cnt_q - CW'(4);
            end else begin
               {cout_d, s_d} = step1(op_q, s_q);
               cnt_d         = cnt_q - CW'(1);
            end
`else
            {cout_d, s_d} = step1(op_q, s_q);
            cnt_d         = cnt_q - CW'(1);
`endif
            if (cnt_d == '0) begin
               state_d = DONE;
            end else begin
               state_d = SHIFT;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         op_q    <= 2'b00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
         op_q    <= op_d;
      end
   end

   assign bus.ready = (state_q == IDLE);
   assign bus.busy  = (state_q == SHIFT) || (state_q == DONE);
   assign bus.done  = (state_q == DONE);
   assign bus.s     = s_q;
   assign bus.cout  = cout_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer (honours SHIFT_MULTISTEP_EN).
module tb_shift_sequencer;
   logic clk;
   logic rst;
   int   n_cmp;
   int   n_fail;
   int   got;
   int   dones;

   shift_sequencer_if #(.WIDTH(16)) bus ();

   shift_sequencer #(.WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_cycle(input int n);
`ifdef SHIFT_MULTISTEP_EN
      return n / 4 + n % 4 + 1;
`else
      return n + 1;
`endif
   endfunction

   task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a     = ~a;
      bus.b     = 16'h0003;
      bus.op    = ~op;
   endtask

   task automatic wait_done(input int first, output int cyc);
      cyc = -1;
      for (int k = first; k <= 40; k++) begin
         @(negedge clk);
         if (bus.done) begin
            cyc = k;
            break;
         end
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b, input int n, input logic [15:0] es, input logic ec);
      int c;
      issue(op, a, b);
      @(negedge clk);
      check({tag, ".ready1"}, {31'd0, bus.ready}, 32'd0);
      check({tag, ".busy1"}, {31'd0, bus.busy}, 32'd1);
      if (bus.done) c = 1;
      else wait_done(2, c);
      check({tag, ".done_cyc"}, c, exp_cycle(n));
      check({tag, ".s"}, {16'd0, bus.s}, {16'd0, es});
      check({tag, ".cout"}, {31'd0, bus.cout}, {31'd0, ec});
      @(negedge clk);
      check({tag, ".done_pulse"}, {31'd0, bus.done}, 32'd0);
      check({tag, ".ready_back"}, {31'd0, bus.ready}, 32'd1);
      check({tag, ".s_held"}, {16'd0, bus.s}, {16'd0, es});
   endtask

   initial begin
      n_cmp     = 0;
      n_fail    = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.op    = 2'b00;
      bus.a     = 16'h0000;
      bus.b     = 16'h0000;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst.ready", {31'd0, bus.ready}, 32'd1);
      check("rst.busy", {31'd0, bus.busy}, 32'd0);
      check("rst.done", {31'd0, bus.done}, 32'd0);
      check("rst.s", {16'd0, bus.s}, 32'd0);
      check("rst.cout", {31'd0, bus.cout}, 32'd0);

      run_op("sll4",   2'b00, 16'h00F1, 16'd4,      4,  16'h0F10, 1'b0);
      run_op("sra1",   2'b10, 16'h8001, 16'd1,      1,  16'hC000, 1'b1);
      run_op("srl1",   2'b01, 16'h8001, 16'd1,      1,  16'h4000, 1'b1);
      run_op("sll_sat",2'b00, 16'hFFFF, 16'd20,     16, 16'h0000, 1'b1);
      run_op("rol17",  2'b11, 16'h8001, 16'd17,     1,  16'h0003, 1'b1);
      run_op("srl0",   2'b01, 16'h1234, 16'd0,      0,  16'h1234, 1'b0);
      run_op("sra_max",2'b10, 16'h8000, 16'hFFFF,   16, 16'hFFFF, 1'b1);
      run_op("rol4",   2'b11, 16'h1234, 16'd4,      4,  16'h2341, 1'b1);
      run_op("srl7",   2'b01, 16'hF0F0, 16'd7,      7,  16'h01E1, 1'b1);

      // start pulsed while busy must not disturb the request in flight
      issue(2'b00, 16'h0001, 16'd3);
      @(negedge clk);
      check("busy.busy1", {31'd0, bus.busy}, 32'd1);
      bus.start = 1'b1;
      bus.op    = 2'b01;
      bus.a     = 16'hFFFF;
      bus.b     = 16'd2;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done(2, got);
      check("busy.done_cyc", got, exp_cycle(3));
      check("busy.s", {16'd0, bus.s}, 32'h0008);
      check("busy.cout", {31'd0, bus.cout}, 32'd0);
      dones = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      check("busy.no_second_done", dones, 0);
      check("busy.s_still", {16'd0, bus.s}, 32'h0008);

      // asynchronous abort in cycle 3 of a 10-position shift
      issue(2'b00, 16'h00FF, 16'd10);
      repeat (3) @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("abort.ready", {31'd0, bus.ready}, 32'd1);
      check("abort.busy", {31'd0, bus.busy}, 32'd0);
      check("abort.done", {31'd0, bus.done}, 32'd0);
      check("abort.s", {16'd0, bus.s}, 32'd0);
      check("abort.cout", {31'd0, bus.cout}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      check("abort.no_done", dones, 0);

      run_op("post_rst", 2'b00, 16'h00F1, 16'd4, 4, 16'h0F10, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
